// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - handshake bundle between fetch, the IF/ID queue and decode
//
// Purpose: groups every non-clock/reset signal of if_id_queue so that fetch,
// decode and the queue share one connection object.
//
// Signals:
//   flush          fetch -> queue   discard all entries (taken branch)
//   inValid        fetch -> queue   fetched entry presented
//   inPC           fetch -> queue   PC of fetched instruction
//   inInstruction  fetch -> queue   fetched instruction word
//   inReady        queue -> fetch   queue accepts an entry this cycle
//   outValid       queue -> decode  head entry available
//   outPC          queue -> decode  PC of head entry
//   outInstruction queue -> decode  instruction of head entry
//   outReady       decode -> queue  decode consumes head entry
//   count          queue -> any     occupancy, 0..DEPTH
//
// Modports: slave is the queue side, master is the surrounding pipeline.

interface if_id_queue_if #(
  parameter int WORD_SIZE = 32,
  parameter int PTR_W     = 2
);
  logic                 flush;
  logic                 inValid;
  logic [WORD_SIZE-1:0] inPC;
  logic [WORD_SIZE-1:0] inInstruction;
  logic                 inReady;
  logic                 outValid;
  logic [WORD_SIZE-1:0] outPC;
  logic [WORD_SIZE-1:0] outInstruction;
  logic                 outReady;
  logic [PTR_W:0]       count;

  modport slave (
    input  flush, inValid, inPC, inInstruction, outReady,
    output inReady, outValid, outPC, outInstruction, count
  );

  modport master (
    output flush, inValid, inPC, inInstruction, outReady,
    input  inReady, outValid, outPC, outInstruction, count
  );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - instruction fetch queue between IF and ID stages
//
// Purpose: DEPTH-entry circular buffer of {PC, instruction} pairs. Fetch
// pushes through inValid/inReady, decode pops through outValid/outReady,
// and a flush (taken branch) empties the queue so wrong-path words never
// reach decode.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   if_id_queue_if.slave: flush, inValid, inPC, inInstruction,
//         inReady, outValid, outPC, outInstruction, outReady, count
//
// Parameters: WORD_SIZE (PC/instruction width), DEPTH (power of two, >= 2),
// PTR_W (log2(DEPTH)).

module if_id_queue #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  if_id_queue_if.slave      bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WORD_SIZE-1:0] pcMem   [DEPTH];
  logic [WORD_SIZE-1:0] instMem [DEPTH];
  logic [PTR_W-1:0]     wp;
  logic [PTR_W-1:0]     rp;
  logic [PTR_W:0]       cnt;

  logic inReadyInt;
  logic outValidInt;
  logic push;
  logic pop;

  // inReady depends only on registered occupancy, so a full queue refuses a
  // push even when decode pops in the same cycle; this keeps outReady off
  // the fetch-side timing path.
  assign inReadyInt  = (cnt != FULL_CNT);
  assign outValidInt = (cnt != '0);

  assign push = bus.inValid & inReadyInt;
  assign pop  = outValidInt & bus.outReady;

  assign bus.inReady        = inReadyInt;
  assign bus.outValid       = outValidInt;
  assign bus.count          = cnt;
  assign bus.outPC          = outValidInt ? pcMem[rp]   : '0;
  assign bus.outInstruction = outValidInt ? instMem[rp] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcMem[i]   <= '0;
        instMem[i] <= '0;
      end
    end else if (bus.flush) begin
      // Storage is left as-is: with cnt at 0 stale words are unreachable.
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        pcMem[wp]   <= bus.inPC;
        instMem[wp] <= bus.inInstruction;
        wp          <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
